audio_sequencer: RTL and testbench

AUDIO_SEQUENCER -- requirements
Module: audio_sequencer

---
 rtl/audio_pkg.sv | 31 +++
 rtl/lfsr16.sv | 29 ++
 rtl/audio_sequencer.sv | 102 ++++++++++
 tb/tb_audio_sequencer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared constants for the audio sequencer: melody ROM, noise LFSR seed and
// feedback taps, voice window offsets and the kick row limit.
package audio_pkg;

    // 16-bit Fibonacci LFSR, polynomial x^16 + x^14 + x^13 + x^11 + 1.
    // The register shifts right, so those taps sit at bits 0, 2, 3 and 5.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    // Left edge of the snare and lead windows, and first row without kick.
    localparam logic [9:0] SNARE_OFFSET   = 10'd32;
    localparam logic [9:0] LEAD_OFFSET    = 10'd64;
    localparam logic [9:0] KICK_ROW_LIMIT = 10'd255;

    // Melody: note-counter reload threshold per step, in scanlines.
    function automatic logic [8:0] note_rom(input logic [2:0] idx);
        logic [8:0] f;
        case (idx)
            3'd0:    f = 9'd151;
            3'd1:    f = 9'd26;
            3'd2:    f = 9'd40;
            3'd3:    f = 9'd60;
            3'd4:    f = 9'd90;
            3'd5:    f = 9'd143;
            3'd6:    f = 9'd23;
            default: f = 9'd35;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR noise source.
//   clk   : clock
//   rst_n : synchronous active-low reset, loads SEED
//   step  : advance one position when high
//   q     : current register contents
module lfsr16
    import audio_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_SEED
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        step,
    output logic [15:0] q
);

    logic feedback;

    assign feedback = ^(q & LFSR_TAPS);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= SEED;
        end else if (step) begin
            q <= {feedback, q[15:1]};
        end
    end

endmodule

// File: rtl/audio_sequencer.sv
// Beam-position driven 1-bit audio sequencer (kick, snare, lead voices).
//   clk         : pixel clock
//   rst_n       : synchronous active-low reset
//   hpos, vpos  : beam column / row
//   line_start  : one-cycle pulse at start of each scanline
//   frame_start : one-cycle pulse at start of each frame
//   mute        : forces audio low, all counters keep running
//   audio       : registered PWM audio output
//   frame_count : timer[12:1]
//   note_idx    : current melody step, timer[7:5]
module audio_sequencer
    import audio_pkg::*;
#(
    parameter logic [2:0]  VOICE_MASK = 3'b111,
    parameter int unsigned NOISE_DIV  = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  hpos,
    input  logic [9:0]  vpos,
    input  logic        line_start,
    input  logic        frame_start,
    input  logic        mute,
    output logic        audio,
    output logic [11:0] frame_count,
    output logic [2:0]  note_idx
);

    localparam int unsigned DIV_W = (NOISE_DIV > 1) ? $clog2(NOISE_DIV) : 1;

    logic [12:0]      timer;
    logic [8:0]       note_cnt;
    logic             note;
    logic [DIV_W-1:0] div;
    logic             div_last;
    logic [15:0]      lfsr_q;
    logic [8:0]       note_freq;
    logic [4:0]       env_a;
    logic [4:0]       env_b;
    logic             kick;
    logic             snare;
    logic             lead;

    assign frame_count = timer[12:1];
    assign note_idx    = timer[7:5];

    // Registered timer feeds the ROM, so a coinciding frame_start does not
    // affect the threshold used on that same line_start.
    assign note_freq = note_rom(timer[7:5]);
    assign env_a     = 5'd31 - timer[4:0];
    assign env_b     = 5'd31 - {timer[3:0], 1'b0};
    assign div_last  = (div == DIV_W'(NOISE_DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            timer    <= '0;
            note_cnt <= '0;
            note     <= 1'b0;
            div      <= '0;
        end else begin
            if (frame_start) begin
                timer <= timer + 13'd1;
            end
            if (line_start) begin
                if (note_cnt > note_freq) begin
                    note_cnt <= '0;
                    note     <= ~note;
                end else begin
                    note_cnt <= note_cnt + 9'd1;
                end
                div <= div_last ? '0 : div + DIV_W'(1);
            end
        end
    end

    lfsr16 #(
        .SEED(LFSR_SEED)
    ) u_lfsr (
        .clk  (clk),
        .rst_n(rst_n),
        .step (line_start & div_last),
        .q    (lfsr_q)
    );

    // Windows are [offset, offset+env); env==0 collapses them to nothing.
    always_comb begin
        kick  = (vpos < KICK_ROW_LIMIT) && (hpos < {5'b0, env_a});
        snare = lfsr_q[0] && (timer[5:4] == 2'b10)
                && (hpos >= SNARE_OFFSET) && (hpos < SNARE_OFFSET + {5'b0, env_b});
        lead  = note
                && (hpos >= LEAD_OFFSET) && (hpos < LEAD_OFFSET + {5'b0, env_b});
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            audio <= 1'b0;
        end else begin
            audio <= ~mute & |({lead, snare, kick} & VOICE_MASK);
        end
    end

endmodule

// File: tb/tb_audio_sequencer.sv
// Self-checking bench for audio_sequencer: a behavioural reference model
// predicts each cycle's audio into a scoreboard queue, popped after the edge.
module tb_audio_sequencer;

    localparam int unsigned NDIV = 3;

    logic        clk;
    logic        rst_n;
    logic [9:0]  hpos;
    logic [9:0]  vpos;
    logic        line_start;
    logic        frame_start;
    logic        mute;
    logic        audio;
    logic [11:0] frame_count;
    logic [2:0]  note_idx;

    audio_sequencer #(
        .VOICE_MASK(3'b111),
        .NOISE_DIV (NDIV)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hpos       (hpos),
        .vpos       (vpos),
        .line_start (line_start),
        .frame_start(frame_start),
        .mute       (mute),
        .audio      (audio),
        .frame_count(frame_count),
        .note_idx   (note_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned total = 0;
    int unsigned bad   = 0;

    logic [12:0] m_timer;
    logic [8:0]  m_cnt;
    logic        m_note;
    int unsigned m_div;
    logic [15:0] m_lfsr;
    logic        exp_q[$];

    int unsigned m_rom[8] = '{151, 26, 40, 60, 90, 143, 23, 35};

    int unsigned snare_hits;
    int unsigned lfsr_steps;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive, predict, advance the model, then compare after the edge.
    task automatic cycle(input logic [9:0] h, input logic [9:0] v, input logic ls,
                         input logic fs, input logic mt, input logic rn);
        int unsigned ea, eb, hh, vv, fb;
        logic k, s, l, e;
        @(negedge clk);
        hpos = h; vpos = v; line_start = ls; frame_start = fs; mute = mt; rst_n = rn;
        if (!rn) begin
            e = 1'b0;
            m_timer = '0; m_cnt = '0; m_note = 1'b0; m_div = 0; m_lfsr = 16'hACE1;
        end else begin
            hh = h; vv = v;
            ea = 31 - m_timer[4:0];
            eb = 31 - 2 * m_timer[3:0];
            k = (vv < 255) && (hh < ea);
            s = m_lfsr[0] && (m_timer[5:4] == 2'd2) && (hh >= 32) && (hh < 32 + eb);
            l = m_note && (hh >= 64) && (hh < 64 + eb);
            e = !mt && (k || s || l);
            if (ls) begin
                if (m_cnt > 9'(m_rom[m_timer[7:5]])) begin
                    m_cnt = '0; m_note = ~m_note;
                end else begin
                    m_cnt = m_cnt + 9'd1;
                end
                if (m_div == NDIV - 1) begin
                    m_div = 0;
                    fb = m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5];
                    m_lfsr = {fb[0], m_lfsr[15:1]};
                    lfsr_steps++;
                end else begin
                    m_div++;
                end
            end
            if (fs) m_timer = m_timer + 13'd1;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        check("audio", 32'(audio), 32'(exp_q.pop_front()));
        check("frame_count", 32'(frame_count), 32'(m_timer[12:1]));
        check("note_idx", 32'(note_idx), 32'(m_timer[7:5]));
        check("note", 32'(dut.note), 32'(m_note));
        check("lfsr", 32'(dut.lfsr_q), 32'(m_lfsr));
        if (rn && !mt && v >= 255 && h >= 32 && h < 64 && audio === 1'b1) snare_hits++;
    endtask

    task automatic do_reset();
        cycle(10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    // A scanline: line_start at hpos 0 (optionally frame_start), then ncols-1 columns.
    task automatic line(input logic [9:0] v, input logic fs, input logic mt, input int unsigned ncols);
        cycle(10'd0, v, 1'b1, fs, mt, 1'b1);
        for (int unsigned c = 1; c < ncols; c++) cycle(10'(c), v, 1'b0, 1'b0, mt, 1'b1);
    endtask

    initial begin
        logic        prev_note;
        int unsigned last_toggle, toggles, steps0;
        hpos = '0; vpos = '0; line_start = 0; frame_start = 0; mute = 0; rst_n = 0;
        snare_hits = 0; lfsr_steps = 0;
        m_timer = '0; m_cnt = '0; m_note = 0; m_div = 0; m_lfsr = 16'hACE1;

        // Reset with coinciding pulses: pulses discarded.
        do_reset();
        check("reset_frame_count", 32'(frame_count), 32'd0);
        check("reset_note_idx", 32'(note_idx), 32'd0);
        check("reset_audio", 32'(audio), 32'd0);

        // First frame: timer becomes 1, kick heard at hpos 1 (envA=30).
        cycle(10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        check("first_frame_count", 32'(frame_count), 32'd0);
        check("first_timer", 32'(dut.timer), 32'd1);
        cycle(10'd1, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("first_audio_hpos1", 32'(audio), 32'd1);

        // timer=0 kick sweep on a visible row, then on row 300 (no kick).
        do_reset();
        line(10'd10, 1'b0, 1'b0, 41);
        line(10'd300, 1'b0, 1'b0, 41);

        // Melody step 1: advance timer to 32, then 200 lines; toggles every 28.
        do_reset();
        for (int unsigned i = 0; i < 32; i++) line(10'd0, 1'b1, 1'b0, 1);
        check("step1_idx", 32'(note_idx), 32'd1);
        prev_note = dut.note; last_toggle = 0; toggles = 0;
        for (int unsigned i = 1; i <= 200; i++) begin
            line(10'd300, 1'b0, 1'b0, (i % 20 == 0) ? 100 : 1);
            if (dut.note !== prev_note) begin
                if (toggles > 0) check("toggle_period", i - last_toggle, 32'd28);
                toggles++; last_toggle = i; prev_note = dut.note;
            end
        end
        check("toggle_count_ok", 32'(toggles >= 7), 32'd1);

        // Timer wrap 8191 -> 0.
        do_reset();
        for (int unsigned i = 0; i < 8191; i++) cycle(10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        check("wrap_pre_fc", 32'(frame_count), 32'd4095);
        check("wrap_pre_idx", 32'(note_idx), 32'd7);
        cycle(10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        check("wrap_fc", 32'(frame_count), 32'd0);
        check("wrap_idx", 32'(note_idx), 32'd0);

        // Noise: timer[5:4]=0 gives no snare; timer=32 (timer[5:4]=2) does.
        do_reset();
        snare_hits = 0; steps0 = lfsr_steps;
        for (int unsigned i = 0; i < 30; i++) line(10'd300, 1'b0, 1'b0, 64);
        check("lfsr_steps", lfsr_steps - steps0, 32'd10);
        check("no_snare_t0", snare_hits, 32'd0);
        for (int unsigned i = 0; i < 32; i++) line(10'd0, 1'b1, 1'b0, 1);
        snare_hits = 0;
        for (int unsigned i = 0; i < 30; i++) line(10'd300, 1'b0, 1'b0, 64);
        check("snare_heard", 32'(snare_hits > 0), 32'd1);

        // Mute for a frame's worth of lines: audio 0, counters keep running.
        for (int unsigned i = 0; i < 40; i++) line(10'(i), 1'b0, 1'b1, 100);
        for (int unsigned i = 0; i < 10; i++) line(10'(i), 1'b0, 1'b0, 100);

        // Reset mid-note restarts the melody.
        do_reset();
        check("rereset_idx", 32'(note_idx), 32'd0);
        check("rereset_note", 32'(dut.note), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1);
    end

endmodule
